wts_i2s_tx: RTL and testbench



---
 rtl/wts_audio_pkg.sv | 22 ++
 rtl/wts_i2s_clkgen.sv | 40 ++++
 rtl/wts_i2s_tx.sv | 91 +++++++++
 tb/tb_wts_i2s_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wts_audio_pkg.sv
// Shared audio definitions for the WTS DAC stages: sample width, default
// framing parameters and the offset-binary to two's-complement MSB rule.
package wts_audio_pkg;

    localparam int unsigned WTS_SAMPLE_BITS   = 12;
    localparam int unsigned WTS_SLOT_BITS_DEF = 16;
    localparam int unsigned WTS_BCLK_DIV_DEF  = 4;

    typedef logic [WTS_SAMPLE_BITS-1:0] wts_sample_t;

    typedef struct packed {
        wts_sample_t left;
        wts_sample_t right;
    } wts_pair_t;

    // Unsigned core samples become two's complement by flipping the MSB.
    function automatic wts_sample_t wts_offset_to_signed(input wts_sample_t x,
                                                         input logic        signed_out);
        return {x[WTS_SAMPLE_BITS-1] ^ signed_out, x[WTS_SAMPLE_BITS-2:0]};
    endfunction

endpackage

// File: rtl/wts_i2s_clkgen.sv
// Bit-clock generator: divides clk into BCLK and flags the cycle before
// each BCLK falling edge.
module wts_i2s_clkgen #(
    parameter int unsigned BCLK_DIV = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic enable,
    output logic bclk,
    output logic fall_tick
);

    localparam int unsigned      DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_bclk;
    logic             w_tick;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (!enable) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    assign bclk      = r_bclk;
    assign fall_tick = w_tick & r_bclk & enable;

endmodule

// File: rtl/wts_i2s_tx.sv
// I2S stereo transmitter: captures a left/right sample pair once per frame
// and shifts it out MSB first with the standard one-BCLK delay after LRCK.
module wts_i2s_tx
    import wts_audio_pkg::*;
#(
    parameter int unsigned BCLK_DIV   = WTS_BCLK_DIV_DEF,
    parameter int unsigned SLOT_BITS  = WTS_SLOT_BITS_DEF,
    parameter int unsigned SIGNED_OUT = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic [11:0] left_in,
    input  logic [11:0] right_in,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_sdata,
    output logic        sample_strobe
);

    localparam int unsigned      FRAME_BITS = 2 * SLOT_BITS;
    localparam int unsigned      BIT_W      = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_RIGHT  = BIT_W'(SLOT_BITS);
    localparam logic             SIGN_FLIP  = (SIGNED_OUT != 0);
    localparam int unsigned      PAD_BITS   = SLOT_BITS - WTS_SAMPLE_BITS;

    logic                  w_bclk;
    logic                  w_fall;
    wts_pair_t             w_pair;
    logic [SLOT_BITS-1:0]  w_lslot;
    logic [SLOT_BITS-1:0]  w_rslot;
    logic [BIT_W-1:0]      w_nxt;

    logic [BIT_W-1:0]      r_bit;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_lrck;
    logic                  r_sdata;
    logic                  r_strobe;

    wts_i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .nreset    (nreset),
        .enable    (enable),
        .bclk      (w_bclk),
        .fall_tick (w_fall)
    );

    assign w_pair  = '{left: left_in, right: right_in};
    // Left-justify the 12-bit sample into the slot, zero-padding below.
    assign w_lslot = SLOT_BITS'(wts_offset_to_signed(w_pair.left,  SIGN_FLIP)) << PAD_BITS;
    assign w_rslot = SLOT_BITS'(wts_offset_to_signed(w_pair.right, SIGN_FLIP)) << PAD_BITS;
    assign w_nxt   = (r_bit == BIT_LAST) ? '0 : r_bit + BIT_W'(1);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_bit    <= BIT_LAST;
            r_shift  <= '0;
            r_lrck   <= 1'b0;
            r_sdata  <= 1'b0;
            r_strobe <= 1'b0;
        end else if (!enable) begin
            r_bit    <= BIT_LAST;
            r_shift  <= '0;
            r_lrck   <= 1'b0;
            r_sdata  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (w_fall) begin
                r_bit   <= w_nxt;
                r_lrck  <= (w_nxt >= BIT_RIGHT);
                r_sdata <= r_shift[FRAME_BITS-1];
                if (w_nxt == '0) begin
                    r_shift  <= {w_lslot, w_rslot};
                    r_strobe <= 1'b1;
                end else begin
                    r_shift  <= {r_shift[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign i2s_bclk      = w_bclk;
    assign i2s_lrck      = r_lrck;
    assign i2s_sdata     = r_sdata;
    assign sample_strobe = r_strobe;

endmodule

// File: tb/tb_wts_i2s_tx.sv
// Directed bench for wts_i2s_tx: default instance plus a BCLK_DIV=1,
// unsigned-output instance, checked against hand-computed frames.
module tb_wts_i2s_tx;

    logic        clk    = 1'b0;
    logic        nreset = 1'b0;
    logic        en0    = 1'b1;
    logic        en1    = 1'b1;
    logic [11:0] l0     = 12'hFFF;
    logic [11:0] r0     = 12'h000;
    logic [11:0] l1     = 12'hA5A;
    logic [11:0] r1     = 12'h3C7;
    logic        bclk0, lrck0, sd0, st0;
    logic        bclk1, lrck1, sd1, st1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wts_i2s_tx dut0 (
        .clk           (clk),
        .nreset        (nreset),
        .enable        (en0),
        .left_in       (l0),
        .right_in      (r0),
        .i2s_bclk      (bclk0),
        .i2s_lrck      (lrck0),
        .i2s_sdata     (sd0),
        .sample_strobe (st0)
    );

    wts_i2s_tx #(
        .BCLK_DIV   (1),
        .SLOT_BITS  (16),
        .SIGNED_OUT (0)
    ) dut1 (
        .clk           (clk),
        .nreset        (nreset),
        .enable        (en1),
        .left_in       (l1),
        .right_in      (r1),
        .i2s_bclk      (bclk1),
        .i2s_lrck      (lrck1),
        .i2s_sdata     (sd1),
        .sample_strobe (st1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // {bclk, lrck, sdata, strobe}
    function automatic logic [3:0] outs(input int sel);
        return (sel != 0) ? {bclk1, lrck1, sd1, st1} : {bclk0, lrck0, sd0, st0};
    endfunction

    task automatic set_left(input int sel, input logic [11:0] v);
        if (sel != 0) l1 = v;
        else          l0 = v;
    endtask

    task automatic wait_strobe(input int sel);
        logic [3:0] o;
        int n;
        n = 0;
        o = outs(sel);
        while (!o[0] && n < 400) begin
            step();
            n++;
            o = outs(sel);
        end
        if (!o[0]) chk("strobe_timeout", 32'd0, 32'd1);
    endtask

    task automatic goto_count(input int sel, input int target);
        logic [3:0] o;
        logic       prev;
        int         k;
        int         n;
        wait_strobe(sel);
        o    = outs(sel);
        prev = o[3];
        k    = 0;
        n    = 0;
        while (k < target && n < 400) begin
            step();
            n++;
            o = outs(sel);
            if (prev && !o[3]) k++;
            prev = o[3];
        end
        if (k != target) chk("count_timeout", k, target);
    endtask

    task automatic capture(input int sel, input int change_at, input logic [11:0] new_left,
                           output logic [31:0] data, output logic [31:0] lr, output int period);
        logic [3:0] o;
        logic       prev;
        int         k;
        wait_strobe(sel);
        o      = outs(sel);
        data   = '0;
        lr     = {31'b0, o[2]};
        k      = 0;
        period = 0;
        prev   = o[3];
        if (change_at == 0) set_left(sel, new_left);
        while (k < 32 && period < 400) begin
            step();
            period++;
            o = outs(sel);
            if (prev && !o[3]) begin
                k++;
                data = {data[30:0], o[1]};
                if (k < 32) lr = {lr[30:0], o[2]};
                if (k == change_at) set_left(sel, new_left);
            end
            prev = o[3];
        end
    endtask

    task automatic reset_first(input string tag);
        logic [3:0] o;
        int rise;
        int strobe;
        rise   = -1;
        strobe = -1;
        nreset = 1'b0;
        repeat (5) step();
        chk({tag, "_rst_out0"}, {28'd0, outs(0)}, 32'd0);
        chk({tag, "_rst_out1"}, {28'd0, outs(1)}, 32'd0);
        nreset = 1'b1;
        for (int c = 0; c < 20 && strobe < 0; c++) begin
            o = outs(0);
            if (c < 4) chk($sformatf("%s_pre_rise_c%0d", tag, c), {28'd0, o}, 32'd0);
            if (o[3] && rise < 0) rise = c;
            if (o[0]) strobe = c;
            else      step();
        end
        chk({tag, "_first_rise"},   rise,   32'd4);
        chk({tag, "_first_strobe"}, strobe, 32'd8);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] lr;
        logic [3:0]  o;
        logic [7:0]  v;
        int          p;
        int          nz;
        int          c;

        reset_first("init");

        capture(0, -1, 12'h000, d, lr, p);
        chk("f1_data",   d,  32'h7FF0_8000);
        chk("f1_lrck",   lr, 32'h0000_FFFF);
        chk("f1_period", p,  32'd256);

        capture(0, 0, 12'h800, d, lr, p);
        chk("f2_data", d, 32'h7FF0_8000);

        capture(0, 5, 12'h123, d, lr, p);
        chk("f3_data", d, 32'h0000_8000);

        capture(0, -1, 12'h000, d, lr, p);
        chk("f4_data", d,  32'h9230_8000);
        chk("f4_lrck", lr, 32'h0000_FFFF);

        for (int i = 0; i < 8; i++) begin
            o    = outs(1);
            v[i] = o[3];
            step();
        end
        chk("div1_bclk_toggle", {25'd0, v[7:1] ^ v[6:0]}, 32'h7F);
        capture(1, -1, 12'h000, d, lr, p);
        chk("div1_data",   d,  32'hA5A0_3C70);
        chk("div1_lrck",   lr, 32'h0000_FFFF);
        chk("div1_period", p,  32'd64);

        goto_count(0, 20);
        o = outs(0);
        chk("en_lrck_at20", {31'd0, o[2]}, 32'd1);
        en0 = 1'b0;
        step();
        chk("en_off_out", {28'd0, outs(0)}, 32'd0);
        nz = 0;
        repeat (300) begin
            step();
            if (outs(0) != 4'd0) nz++;
        end
        chk("en_off_quiet", nz, 32'd0);
        en0 = 1'b1;
        c   = 0;
        o   = outs(0);
        while (!o[0] && c < 40) begin
            step();
            c++;
            o = outs(0);
        end
        chk("en_restart_strobe", c, 32'd8);

        goto_count(0, 20);
        o = outs(0);
        chk("async_lrck_at20", {31'd0, o[2]}, 32'd1);
        #1;
        nreset = 1'b0;
        #1;
        chk("async_out0", {28'd0, outs(0)}, 32'd0);
        chk("async_out1", {28'd0, outs(1)}, 32'd0);
        reset_first("rerun");

        capture(0, -1, 12'h000, d, lr, p);
        chk("rerun_data", d, 32'h9230_8000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
